zx8x_sync_gen: RTL and testbench
================================

// Module: zx8x_sync_gen
// PURPOSE
// Parametrised sync/NMI generator for the ZX80/ZX81 core: owns the T-state line counter, HSYNC window,
// ZX81 NMI latch and NMI/WAIT generation, the IN/OUT-driven VSYNC flop, character row counter and
// back-porch blanking. Replaces the inline sync logic in the top level; generalises line length,
// sync window, row/porch widths and adds an optional ZX80 M1-derived csync path.
// PARAMETERS
// LINE_LEN    207  T-states per scanline; counter range 0..LINE_LEN-1
// HS_START    16   first counter value with hsync=1
// HS_END      31   last counter value with hsync=1 (HS_START<=HS_END<LINE_LEN)
// ROW_BITS    3    width of character row counter
// BP_BITS     5    width of back-porch counter (blank length 2^BP_BITS-1 pixels)
// M1_SYNC     0    1: csync comes from the ZX80 IORQ/M1 flop chain when zx81=0
// PORTS
// clk_sys   in   1         system clock (52 MHz)
// reset     in   1         synchronous, active-high
// ce_cpu_n  in   1         CPU negative-phase clock enable (one T-state per pulse)
// ce_pix    in   1         pixel clock enable (6.5 MHz)
// zx81      in   1         1: ZX81 NMI mode active
// nM1,nIORQ,nRD,nWR,nHALT in 1 each  CPU bus strobes, active low
// addr_lo   in   2         CPU addr[1:0]
// kbd_n     in   1         0 during keyboard port read (IN from even port)
// hsync     out  1         line sync, active high
// vsync     out  1         0 during vertical sync
// csync     out  1         composite sync, active low
// nNMI      out  1         CPU NMI, active low
// nWAIT     out  1         CPU WAIT, active low
// nmi_on    out  1         NMI latch state
// row       out  ROW_BITS  character row within text line
// blank     out  1         1 during back porch
// BEHAVIOUR
// - Reset: cnt=0, nmi_on=0, vsync=1, row=0, bp=0 (blank=0), ZX80 chain ic18=0, ic19_1=ic19_2=1;
//   so hsync=0, nNMI=1, nWAIT=1, csync=1 in the cycle after reset. Reset mid-line aborts all state.
// - T-state tick = falling edge of ce_cpu_n (registered copy 1, current 0); all counting on ticks.
// - cnt width = $clog2(LINE_LEN). On tick: cnt<=cnt+1; cnt<=0 if cnt==LINE_LEN-1 or (~nM1&~nIORQ)
//   (interrupt ack resyncs line). Never exceeds LINE_LEN-1.
// - hsync = (cnt>=HS_START)&&(cnt<=HS_END), combinational from cnt register.
// - NMI latch: if zx81 & ~nIORQ & ~nWR & (addr_lo[0]^addr_lo[1]) then nmi_on<=addr_lo[1]
//   (OUT FEh on, OUT FDh off). zx81=0 forces nmi_on<=0 next cycle.
// - nNMI = ~(nmi_on & hsync). nWAIT = ~(nHALT & ~nNMI). Both forced 1 when zx81=0. Combinational.
// - Gate g = ~(zx81 & nmi_on). vsync<=1 on g&~nIORQ&~nWR (any OUT); vsync<=0 on g&~kbd_n.
//   Both in same cycle: clear (0) wins.
// - csync = vsync & ~hsync, except M1_SYNC=1 & zx81=0: csync = ic19_2.
// - ZX80 chain: ic18<=1 on ~nIORQ; ic18<=0 when ic19_2=0 (clear wins). On nM1 falling edge:
//   ic19_1<=~ic18, ic19_2<=ic19_1. vsync=0 forces ic19_2<=0 (overrides shift).
// - row: +1 on csync falling edge (registered detect), wraps mod 2^ROW_BITS; vsync=0 holds row=0.
// - bp: csync rising edge loads 1; on ce_pix while bp!=0, bp<=bp+1, wraps to 0 ending porch.
//   blank = (bp!=0). Rising edge coinciding with ce_pix: load 1 wins.
// - 1-cycle latency on all registered outputs; no handshakes, outputs always valid.
// TESTING
// - Free-run zx81=1, no IORQ: cnt wraps 206->0; hsync high for exactly 16 ticks per 207.
// - OUT FEh (addr_lo=2'b10) -> nmi_on=1; at cnt=16 nNMI=0; with nHALT=1 nWAIT=0; OUT FDh -> nmi_on=0.
// - zx81=0: IN kbd (kbd_n=0) -> vsync=0, row held 0; OUT -> vsync=1; csync follows ~hsync.
// - ~nM1&~nIORQ at cnt=100 -> next tick cnt=0; hsync starts 16 ticks later.
// - csync rising edge -> blank=1 for 31 ce_pix pulses, then 0; 8 csync falls -> row wraps 7->0.
// - M1_SYNC=1, zx81=0: IORQ pulse then 2 M1 falls -> csync=0; reset mid-sync -> all outputs idle values.

Source files
------------

// File: rtl/zx8x_sync_gen.sv
// zx8x_sync_gen: ZX80/ZX81 sync and NMI generator.
// Owns the T-state line counter, HSYNC window, ZX81 NMI latch with NMI/WAIT
// generation, IN/OUT-driven VSYNC flop, optional ZX80 M1-derived csync chain,
// character row counter and back-porch blanking.
module zx8x_sync_gen #(
    parameter int unsigned LINE_LEN = 207,
    parameter int unsigned HS_START = 16,
    parameter int unsigned HS_END   = 31,
    parameter int unsigned ROW_BITS = 3,
    parameter int unsigned BP_BITS  = 5,
    parameter bit          M1_SYNC  = 1'b0
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ce_cpu_n,
    input  logic                ce_pix,
    input  logic                zx81,
    input  logic                nM1,
    input  logic                nIORQ,
    input  logic                nRD,
    input  logic                nWR,
    input  logic                nHALT,
    input  logic [1:0]          addr_lo,
    input  logic                kbd_n,
    output logic                hsync,
    output logic                vsync,
    output logic                csync,
    output logic                nNMI,
    output logic                nWAIT,
    output logic                nmi_on,
    output logic [ROW_BITS-1:0] row,
    output logic                blank
);

    localparam int unsigned CNT_BITS = $clog2(LINE_LEN);
    localparam logic [CNT_BITS-1:0] CNT_LAST     = CNT_BITS'(LINE_LEN - 1);
    localparam logic [CNT_BITS-1:0] CNT_HS_START = CNT_BITS'(HS_START);
    localparam logic [CNT_BITS-1:0] CNT_HS_END   = CNT_BITS'(HS_END);

    logic [CNT_BITS-1:0] cnt;
    logic [BP_BITS-1:0]  bp;
    logic                ce_cpu_n_d;
    logic                nM1_d;
    logic                csync_d;
    logic                ic18;
    logic                ic19_1;
    logic                ic19_2;
    logic                tick;
    logic                m1_fall;
    logic                csync_fall;
    logic                csync_rise;
    logic                resync;
    logic                out_wr;
    logic                gate;
    logic                unused_nrd;

    // Read strobe is part of the bus bundle but no sync function depends on it
    assign unused_nrd = nRD;

    // Registered copies of the strobes whose edges drive the state below
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ce_cpu_n_d <= 1'b0;
            nM1_d      <= 1'b1;
            csync_d    <= 1'b1;
        end else begin
            ce_cpu_n_d <= ce_cpu_n;
            nM1_d      <= nM1;
            csync_d    <= csync;
        end
    end

    // Edge detects and decoded bus cycles
    always_comb begin
        tick       = ce_cpu_n_d & ~ce_cpu_n;
        m1_fall    = nM1_d & ~nM1;
        csync_fall = csync_d & ~csync;
        csync_rise = ~csync_d & csync;
        resync     = ~nM1 & ~nIORQ;
        out_wr     = ~nIORQ & ~nWR;
        gate       = ~(zx81 & nmi_on);
    end

    // T-state line counter; an interrupt acknowledge restarts the line
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            if ((cnt == CNT_LAST) || resync) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_BITS'(1);
            end
        end
    end

    // ZX81 NMI latch: OUT FEh enables, OUT FDh disables
    always_ff @(posedge clk_sys) begin
        if (reset || !zx81) begin
            nmi_on <= 1'b0;
        end else if (out_wr && (addr_lo[0] ^ addr_lo[1])) begin
            nmi_on <= addr_lo[1];
        end
    end

    // VSYNC flop: keyboard read starts vertical sync, any OUT ends it
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vsync <= 1'b1;
        end else if (gate && !kbd_n) begin
            vsync <= 1'b0;
        end else if (gate && out_wr) begin
            vsync <= 1'b1;
        end
    end

    // ZX80 IORQ/M1 flop chain; the vsync clear is applied last so it overrides the shift
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ic18   <= 1'b0;
            ic19_1 <= 1'b1;
            ic19_2 <= 1'b1;
        end else begin
            if (!ic19_2) begin
                ic18 <= 1'b0;
            end else if (!nIORQ) begin
                ic18 <= 1'b1;
            end
            if (m1_fall) begin
                ic19_1 <= ~ic18;
                ic19_2 <= ic19_1;
            end
            if (!vsync) begin
                ic19_2 <= 1'b0;
            end
        end
    end

    // Character row counter, advanced on each csync fall and held at 0 in vsync
    always_ff @(posedge clk_sys) begin
        if (reset || !vsync) begin
            row <= '0;
        end else if (csync_fall) begin
            row <= row + ROW_BITS'(1);
        end
    end

    // Back-porch counter: started by csync rise, runs on pixel enables until it wraps
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bp <= '0;
        end else if (csync_rise) begin
            bp <= BP_BITS'(1);
        end else if (ce_pix && (bp != '0)) begin
            bp <= bp + BP_BITS'(1);
        end
    end

    // Combinational sync, NMI/WAIT and blanking outputs
    always_comb begin
        hsync = (cnt >= CNT_HS_START) && (cnt <= CNT_HS_END);
        nNMI  = 1'b1;
        nWAIT = 1'b1;
        if (zx81) begin
            nNMI  = ~(nmi_on & hsync);
            nWAIT = ~(nHALT & ~nNMI);
        end
        csync = (M1_SYNC && !zx81) ? ic19_2 : (vsync & ~hsync);
        blank = (bp != '0);
    end

endmodule

// File: tb/tb_zx8x_sync_gen.sv
// tb_zx8x_sync_gen: scoreboard bench for zx8x_sync_gen (default and M1_SYNC=1 instances).
module tb_zx8x_sync_gen;

    localparam int LINE_LEN = 207;
    localparam int HS_START = 16;
    localparam int HS_END   = 31;
    localparam logic [15:0] IDLE_ST = 16'h01E0;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    logic       clk_sys = 1'b0;
    logic       reset, ce_cpu_n, ce_pix, zx81;
    logic       nM1, nIORQ, nRD, nWR, nHALT, kbd_n;
    logic [1:0] addr_lo;

    logic       hsync, vsync, csync, nNMI, nWAIT, nmi_on, blank;
    logic [2:0] row;
    logic       m_hsync, m_vsync, m_csync, m_nNMI, m_nWAIT, m_nmi_on, m_blank;
    logic [2:0] m_row;

    wire [9:0] st   = {hsync, vsync, csync, nNMI, nWAIT, nmi_on, blank, row};
    wire [9:0] st_m = {m_hsync, m_vsync, m_csync, m_nNMI, m_nWAIT, m_nmi_on, m_blank, m_row};

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   m_cnt = 0;

    always #5 clk_sys = ~clk_sys;

    zx8x_sync_gen dut (
        .clk_sys(clk_sys), .reset(reset), .ce_cpu_n(ce_cpu_n), .ce_pix(ce_pix),
        .zx81(zx81), .nM1(nM1), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nHALT(nHALT),
        .addr_lo(addr_lo), .kbd_n(kbd_n), .hsync(hsync), .vsync(vsync), .csync(csync),
        .nNMI(nNMI), .nWAIT(nWAIT), .nmi_on(nmi_on), .row(row), .blank(blank)
    );

    zx8x_sync_gen #(.M1_SYNC(1'b1)) dut_m1 (
        .clk_sys(clk_sys), .reset(reset), .ce_cpu_n(ce_cpu_n), .ce_pix(ce_pix),
        .zx81(zx81), .nM1(nM1), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nHALT(nHALT),
        .addr_lo(addr_lo), .kbd_n(kbd_n), .hsync(m_hsync), .vsync(m_vsync), .csync(m_csync),
        .nNMI(m_nNMI), .nWAIT(m_nWAIT), .nmi_on(m_nmi_on), .row(m_row), .blank(m_blank)
    );

    // ---------------- stimulus primitives ----------------
    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1; ce_cpu_n = 1'b1; ce_pix = 1'b0;
        nM1 = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nHALT = 1'b1;
        addr_lo = 2'b00; kbd_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        m_cnt = 0;
        @(negedge clk_sys);
    endtask

    task automatic tick(input bit ack);
        @(negedge clk_sys);
        ce_cpu_n = 1'b0;
        if (ack) begin
            nM1 = 1'b0; nIORQ = 1'b0;
        end
        @(negedge clk_sys);
        ce_cpu_n = 1'b1; nM1 = 1'b1; nIORQ = 1'b1;
        if (ack || m_cnt == LINE_LEN - 1) m_cnt = 0;
        else m_cnt = m_cnt + 1;
    endtask

    task automatic tick_to(input int target);
        while (m_cnt != target) tick(1'b0);
    endtask

    task automatic out_cycle(input logic [1:0] a);
        @(negedge clk_sys);
        nIORQ = 1'b0; nWR = 1'b0; addr_lo = a;
        @(negedge clk_sys);
        nIORQ = 1'b1; nWR = 1'b1;
    endtask

    task automatic kbd_cycle(input bit with_out);
        @(negedge clk_sys);
        kbd_n = 1'b0;
        if (with_out) begin
            nIORQ = 1'b0; nWR = 1'b0;
        end
        @(negedge clk_sys);
        kbd_n = 1'b1; nIORQ = 1'b1; nWR = 1'b1;
    endtask

    task automatic pix_pulse();
        @(negedge clk_sys);
        ce_pix = 1'b1;
        @(negedge clk_sys);
        ce_pix = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        zx81 = 1'b1;
        do_reset();
        sb.push_back('{"reset_state", IDLE_ST});
        sb.push_back('{"reset_state_m1", IDLE_ST});
        e = sb.pop_front(); checks++;
        if (16'(st) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, st, e.val); end
        e = sb.pop_front(); checks++;
        if (16'(st_m) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, st_m, e.val); end
    endtask

    task automatic test_free_run();
        int hs_seen;
        zx81 = 1'b1;
        for (int line = 0; line < 2; line++) begin
            hs_seen = 0;
            sb.push_back('{"hsync_width", 16'd16});
            for (int t = 0; t < LINE_LEN; t++) begin
                tick(1'b0);
                sb.push_back('{"free_hsync", 16'(m_cnt >= HS_START && m_cnt <= HS_END)});
                sb.push_back('{"free_csync", 16'(!(m_cnt >= HS_START && m_cnt <= HS_END))});
                e = sb.pop_back(); checks++;
                if (16'(m_csync) !== e.val) begin failures++; $display("FAIL %s: cnt=%0d got %0h expected %0h", e.name, m_cnt, m_csync, e.val); end
                e = sb.pop_back(); checks++;
                if (16'(hsync) !== e.val) begin failures++; $display("FAIL %s: cnt=%0d got %0h expected %0h", e.name, m_cnt, hsync, e.val); end
                if (hsync === 1'b1) hs_seen++;
            end
            e = sb.pop_front(); checks++;
            if (16'(hs_seen) !== e.val) begin failures++; $display("FAIL %s: got %0d expected %0d", e.name, hs_seen, e.val); end
        end
    endtask

    task automatic test_nmi();
        zx81 = 1'b1;
        sb.push_back('{"nmi_on_set", 16'd1});
        out_cycle(2'b10);
        e = sb.pop_front(); checks++;
        if (16'(nmi_on) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, nmi_on, e.val); end

        tick_to(HS_START - 1);
        sb.push_back('{"nNMI_before_window", 16'd1});
        e = sb.pop_front(); checks++;
        if (16'(nNMI) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, nNMI, e.val); end

        tick(1'b0);
        sb.push_back('{"nNMI_window", 16'd0});
        sb.push_back('{"nWAIT_window", 16'd0});
        e = sb.pop_front(); checks++;
        if (16'(nNMI) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, nNMI, e.val); end
        e = sb.pop_front(); checks++;
        if (16'(nWAIT) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, nWAIT, e.val); end

        nHALT = 1'b0;
        sb.push_back('{"nWAIT_halted", 16'd1});
        #1;
        e = sb.pop_front(); checks++;
        if (16'(nWAIT) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, nWAIT, e.val); end
        nHALT = 1'b1;

        sb.push_back('{"vsync_gated_by_nmi", 16'd1});
        kbd_cycle(1'b0);
        e = sb.pop_front(); checks++;
        if (16'(vsync) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, vsync, e.val); end

        sb.push_back('{"nmi_on_hold_port3", 16'd1});
        out_cycle(2'b11);
        e = sb.pop_front(); checks++;
        if (16'(nmi_on) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, nmi_on, e.val); end

        tick_to(HS_END + 1);
        sb.push_back('{"nNMI_after_window", 16'd1});
        e = sb.pop_front(); checks++;
        if (16'(nNMI) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, nNMI, e.val); end

        sb.push_back('{"nmi_on_clear", 16'd0});
        out_cycle(2'b01);
        e = sb.pop_front(); checks++;
        if (16'(nmi_on) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, nmi_on, e.val); end

        out_cycle(2'b10);
        tick_to(HS_START);
        @(negedge clk_sys);
        zx81 = 1'b0;
        sb.push_back('{"nNMI_zx80_forced", 16'd1});
        sb.push_back('{"nWAIT_zx80_forced", 16'd1});
        #1;
        e = sb.pop_front(); checks++;
        if (16'(nNMI) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, nNMI, e.val); end
        e = sb.pop_front(); checks++;
        if (16'(nWAIT) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, nWAIT, e.val); end
        sb.push_back('{"nmi_on_zx80_cleared", 16'd0});
        @(negedge clk_sys);
        e = sb.pop_front(); checks++;
        if (16'(nmi_on) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, nmi_on, e.val); end
        zx81 = 1'b1;
        sb.push_back('{"nNMI_latch_gone", 16'd1});
        #1;
        e = sb.pop_front(); checks++;
        if (16'(nNMI) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, nNMI, e.val); end
    endtask

    task automatic test_resync();
        zx81 = 1'b1;
        tick_to(100);
        tick(1'b1);
        for (int t = 0; t < 40; t++) begin
            tick(1'b0);
            sb.push_back('{"resync_hsync", 16'(m_cnt >= HS_START && m_cnt <= HS_END)});
            e = sb.pop_front(); checks++;
            if (16'(hsync) !== e.val) begin failures++; $display("FAIL %s: ticks_after_ack=%0d got %0h expected %0h", e.name, t + 1, hsync, e.val); end
        end
    endtask

    task automatic test_row_wrap();
        zx81 = 1'b0;
        do_reset();
        for (int line = 1; line <= 8; line++) begin
            sb.push_back('{"row_per_line", 16'(line % 8)});
            repeat (LINE_LEN) tick(1'b0);
            e = sb.pop_front(); checks++;
            if (16'(row) !== e.val) begin failures++; $display("FAIL %s: line=%0d got %0d expected %0d", e.name, line, row, e.val); end
        end
    endtask

    task automatic test_back_porch();
        zx81 = 1'b0;
        do_reset();
        tick_to(HS_END);
        tick(1'b0);
        sb.push_back('{"blank_latency", 16'd0});
        e = sb.pop_front(); checks++;
        if (16'(blank) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, blank, e.val); end
        sb.push_back('{"blank_load", 16'd1});
        @(negedge clk_sys);
        e = sb.pop_front(); checks++;
        if (16'(blank) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, blank, e.val); end
        for (int k = 1; k <= 30; k++) begin
            sb.push_back('{"blank_run", 16'd1});
            pix_pulse();
            e = sb.pop_front(); checks++;
            if (16'(blank) !== e.val) begin failures++; $display("FAIL %s: pulse=%0d got %0h expected %0h", e.name, k, blank, e.val); end
        end
        // counter now sits one pulse from wrapping; next csync rise coincides with ce_pix
        tick_to(HS_END);
        tick(1'b0);
        ce_pix = 1'b1;
        sb.push_back('{"blank_load_beats_pix", 16'd1});
        @(negedge clk_sys);
        ce_pix = 1'b0;
        e = sb.pop_front(); checks++;
        if (16'(blank) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, blank, e.val); end
        for (int k = 1; k <= 31; k++) begin
            sb.push_back('{"blank_length", 16'(k < 31)});
            pix_pulse();
            e = sb.pop_front(); checks++;
            if (16'(blank) !== e.val) begin failures++; $display("FAIL %s: pulse=%0d got %0h expected %0h", e.name, k, blank, e.val); end
        end
    endtask

    task automatic test_zx80_vsync();
        zx81 = 1'b0;
        do_reset();
        tick_to(20);
        sb.push_back('{"row_first_fall", 16'd1});
        sb.push_back('{"csync_in_hsync", 16'd0});
        e = sb.pop_front(); checks++;
        if (16'(row) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, row, e.val); end
        e = sb.pop_front(); checks++;
        if (16'(csync) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, csync, e.val); end

        sb.push_back('{"vsync_kbd_read", 16'd0});
        kbd_cycle(1'b0);
        e = sb.pop_front(); checks++;
        if (16'(vsync) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, vsync, e.val); end
        sb.push_back('{"row_cleared", 16'd0});
        @(negedge clk_sys);
        e = sb.pop_front(); checks++;
        if (16'(row) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, row, e.val); end

        tick_to(40);
        sb.push_back('{"row_held_in_vsync", 16'd0});
        sb.push_back('{"csync_in_vsync", 16'd0});
        e = sb.pop_front(); checks++;
        if (16'(row) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, row, e.val); end
        e = sb.pop_front(); checks++;
        if (16'(csync) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, csync, e.val); end

        sb.push_back('{"vsync_out_end", 16'd1});
        sb.push_back('{"csync_after_vsync", 16'd1});
        out_cycle(2'b00);
        e = sb.pop_front(); checks++;
        if (16'(vsync) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, vsync, e.val); end
        e = sb.pop_front(); checks++;
        if (16'(csync) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, csync, e.val); end

        sb.push_back('{"vsync_clear_wins", 16'd0});
        kbd_cycle(1'b1);
        e = sb.pop_front(); checks++;
        if (16'(vsync) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, vsync, e.val); end

        sb.push_back('{"vsync_out_again", 16'd1});
        out_cycle(2'b00);
        e = sb.pop_front(); checks++;
        if (16'(vsync) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, vsync, e.val); end

        tick_to(HS_START);
        sb.push_back('{"csync_follows_hsync", 16'd0});
        e = sb.pop_front(); checks++;
        if (16'(csync) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, csync, e.val); end
    endtask

    task automatic test_m1_sync();
        zx81 = 1'b0;
        do_reset();
        @(negedge clk_sys);
        nIORQ = 1'b0;
        @(negedge clk_sys);
        nIORQ = 1'b1;
        sb.push_back('{"m1_csync_after_iorq", 16'd1});
        e = sb.pop_front(); checks++;
        if (16'(m_csync) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, m_csync, e.val); end

        for (int f = 1; f <= 2; f++) begin
            sb.push_back('{"m1_csync_after_fall", 16'(f < 2)});
            @(negedge clk_sys);
            nM1 = 1'b0;
            @(negedge clk_sys);
            nM1 = 1'b1;
            e = sb.pop_front(); checks++;
            if (16'(m_csync) !== e.val) begin failures++; $display("FAIL %s: fall=%0d got %0h expected %0h", e.name, f, m_csync, e.val); end
        end
        sb.push_back('{"csync_no_m1_path", 16'd1});
        e = sb.pop_front(); checks++;
        if (16'(csync) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, csync, e.val); end

        zx81 = 1'b1;
        sb.push_back('{"m1_csync_zx81_mode", 16'd1});
        #1;
        e = sb.pop_front(); checks++;
        if (16'(m_csync) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, m_csync, e.val); end
        zx81 = 1'b0;
        sb.push_back('{"m1_csync_back", 16'd0});
        #1;
        e = sb.pop_front(); checks++;
        if (16'(m_csync) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, m_csync, e.val); end

        tick_to(20);
        do_reset();
        sb.push_back('{"midsync_reset", IDLE_ST});
        sb.push_back('{"midsync_reset_m1", IDLE_ST});
        e = sb.pop_front(); checks++;
        if (16'(st) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, st, e.val); end
        e = sb.pop_front(); checks++;
        if (16'(st_m) !== e.val) begin failures++; $display("FAIL %s: got %0h expected %0h", e.name, st_m, e.val); end
    endtask

    initial begin
        reset = 1'b1; ce_cpu_n = 1'b1; ce_pix = 1'b0; zx81 = 1'b1;
        nM1 = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nHALT = 1'b1;
        addr_lo = 2'b00; kbd_n = 1'b1;
        test_reset();
        test_free_run();
        test_nmi();
        test_resync();
        test_row_wrap();
        test_back_porch();
        test_zx80_vsync();
        test_m1_sync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
